// File: rtl/wb_master_pkg.sv
// Shared types for the Wishbone single-transfer initiator.
// Request/response bundles and the FSM state encoding.
package wb_master_pkg;

  localparam int WBM_ADDR_W = 32;
  localparam int WBM_DATA_W = 32;
  localparam int WBM_SEL_W  = WBM_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wbm_state_e;

  typedef struct packed {
    logic                  we;
    logic [WBM_ADDR_W-1:0] adr;
    logic [WBM_DATA_W-1:0] dat;
    logic [WBM_SEL_W-1:0]  sel;
  } wbm_req_t;

  typedef struct packed {
    logic [WBM_DATA_W-1:0] dat;
    logic                  err;
    logic                  timeout;
  } wbm_rsp_t;

  // A disabled timeout still needs a 1-bit counter to keep widths legal.
  function automatic int cnt_width(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_req_master.sv
// Wishbone classic initiator: one request in, one bus cycle out,
// one response back, with a bounded wait for ack/err.
module wb_req_master
  import wb_master_pkg::*;
#(
  parameter int ADDR_W         = WBM_ADDR_W,
  parameter int DATA_W         = WBM_DATA_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_adr_i,
  input  logic [DATA_W-1:0]   req_dat_i,
  input  logic [DATA_W/8-1:0] req_sel_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  output logic                rsp_timeout_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_err_i,
  output logic                busy_o
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  wbm_state_e       r_state;
  wbm_state_e       w_next;
  wbm_req_t         r_req;
  wbm_rsp_t         r_rsp;
  wbm_rsp_t         w_rsp_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_load;
  logic             w_rsp_set;
  logic             w_rsp_clr;
  logic             w_tmo;

  assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_rsp_set = 1'b0;
    w_rsp_clr = 1'b0;
    w_rsp_nxt = '0;
    unique case (r_state)
      IDLE: begin
        if (req_valid_i) begin
          w_load = 1'b1;
          w_next = BUS;
        end
      end
      BUS: begin
        // err outranks ack; a late ack still beats the timeout
        if (wb_err_i) begin
          w_rsp_set     = 1'b1;
          w_rsp_nxt.err = 1'b1;
          w_next        = RESP;
        end else if (wb_ack_i) begin
          w_rsp_set     = 1'b1;
          w_rsp_nxt.dat = r_req.we ? '0 : wb_dat_i;
          w_next        = RESP;
        end else if (w_tmo) begin
          w_rsp_set         = 1'b1;
          w_rsp_nxt.timeout = 1'b1;
          w_next            = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          w_rsp_clr = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_req <= '0;
    end else if (w_load) begin
      r_req.we  <= req_we_i;
      r_req.adr <= req_adr_i;
      r_req.dat <= req_dat_i;
      r_req.sel <= req_sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= '0;
    end else if (r_state == BUS) begin
      if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_rsp <= '0;
    end else if (w_rsp_set) begin
      r_rsp <= w_rsp_nxt;
    end else if (w_rsp_clr) begin
      r_rsp.err     <= 1'b0;
      r_rsp.timeout <= 1'b0;
    end
  end

  assign req_ready_o   = (r_state == IDLE);
  assign wb_cyc_o      = (r_state == BUS);
  assign wb_stb_o      = (r_state == BUS);
  assign rsp_valid_o   = (r_state == RESP);
  assign busy_o        = (r_state != IDLE);
  assign wb_we_o       = r_req.we;
  assign wb_adr_o      = r_req.adr;
  assign wb_dat_o      = r_req.dat;
  assign wb_sel_o      = r_req.sel;
  assign rsp_dat_o     = r_rsp.dat;
  assign rsp_err_o     = r_rsp.err;
  assign rsp_timeout_o = r_rsp.timeout;

endmodule

// File: tb/tb_wb_req_master.sv
// Bench for wb_req_master: directed and random transfers
// against a transaction-level expectation and a slave model.
module tb_wb_req_master;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        rsp_tmo;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [31:0] s_rdata = '0;
  logic        s_ack, s_err;
  logic        busy;

  int s_mode = 0;
  int s_lat  = 0;
  int s_wait;
  int n_vec  = 0;
  int n_miss = 0;

  wb_req_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_adr_i(req_adr),
    .req_dat_i(req_dat), .req_sel_i(req_sel),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
    .rsp_timeout_o(rsp_tmo),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we),
    .wb_adr_o(adr), .wb_dat_o(wdat), .wb_sel_o(sel),
    .wb_dat_i(s_rdata), .wb_ack_i(s_ack), .wb_err_i(s_err),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  // Registered-response slave; mode 0 ack, 1 err, 2 both, 3 silent.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack  <= 1'b0;
      s_err  <= 1'b0;
      s_wait <= 0;
    end else begin
      s_ack <= 1'b0;
      s_err <= 1'b0;
      if (cyc && stb && !s_ack && !s_err) begin
        if (s_wait >= s_lat && s_mode != 3) begin
          s_ack <= (s_mode == 0 || s_mode == 2);
          s_err <= (s_mode == 1 || s_mode == 2);
        end
        s_wait <= s_wait + 1;
      end else if (!cyc) begin
        s_wait <= 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [31:0] e_dat;
  logic        e_err, e_tmo;

  task automatic xfer(input logic x_we, input logic [31:0] x_adr,
                      input logic [31:0] x_dat, input logic [3:0] x_sel,
                      input int mode, input int lat,
                      input logic [31:0] rd, input bit consume);
    int  n_cyc;
    int  n_wait;
    int  e_cyc;
    bit  done;
    s_mode  = mode;
    s_lat   = lat;
    s_rdata = rd;
    e_err = (mode == 1 || mode == 2);
    e_tmo = (mode == 3);
    e_dat = (mode == 0 && !x_we) ? rd : 32'h0;
    e_cyc = e_tmo ? TMO : lat + 2;
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_we  = x_we;
    req_adr = x_adr;
    req_dat = x_dat;
    req_sel = x_sel;
    @(negedge clk);
    req_valid = 1'b0;
    req_we  = ~x_we;
    req_adr = $urandom;
    req_dat = $urandom;
    req_sel = 4'($urandom);
    n_cyc  = 0;
    n_wait = 0;
    done   = 0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (rsp_valid) begin
        done = 1;
      end else begin
        n_wait++;
        if (cyc) begin
          n_cyc++;
          chk("wb_stb", stb, 1);
          chk("wb_adr", adr, x_adr);
          chk("wb_dat", wdat, x_dat);
          chk("wb_sel", sel, x_sel);
          chk("wb_we", we, x_we);
        end
        @(negedge clk);
      end
    end
    chk("rsp_within_budget", done, 1);
    chk("cyc_cycles", n_cyc, e_cyc);
    chk("rsp_latency", n_wait, e_cyc);
    chk("cyc_low_in_resp", cyc, 0);
    chk("rsp_dat", rsp_dat, e_dat);
    chk("rsp_err", rsp_err, e_err);
    chk("rsp_timeout", rsp_tmo, e_tmo);
    if (consume) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("idle_after_rsp", busy, 0);
      chk("rsp_valid_drop", rsp_valid, 0);
      chk("rsp_flags_clr", {rsp_err, rsp_tmo}, 0);
    end
  endtask

  initial begin
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_cyc", {cyc, stb, we}, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp", {rsp_dat, rsp_err, rsp_tmo}, 0);
    chk("rst_bus", {adr, wdat, sel}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    xfer(1'b0, 32'h04, 32'h0, 4'hF, 0, 0, 32'hA5A5_0F0F, 1);
    xfer(1'b1, 32'h08, 32'h1234_5678, 4'b0101, 0, 1, 32'hDEAD_BEEF, 1);
    xfer(1'b0, 32'h0C, 32'h0, 4'hF, 2, 0, 32'h5555_AAAA, 1);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, 3, 0, 32'h7777_7777, 1);
    xfer(1'b0, 32'h14, 32'h0, 4'hF, 0, 5, 32'h0BAD_F00D, 1);

    // Back-pressure with a second request waiting.
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 0, 0, 32'hCAFE_0001, 0);
    req_valid = 1'b1;
    req_we  = 1'b1;
    req_adr = 32'h24;
    req_dat = 32'h0F0F_F0F0;
    req_sel = 4'b0011;
    s_mode  = 0;
    s_lat   = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_dat", rsp_dat, 32'hCAFE_0001);
      chk("bp_rsp_flags", {rsp_err, rsp_tmo}, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_idle", busy, 0);
    chk("bp_req_ready_back", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_next_cyc", cyc, 1);
    chk("bp_next_adr", adr, 32'h24);
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    chk("bp_next_rsp", {rsp_valid, rsp_err, rsp_tmo}, 3'b100);
    chk("bp_next_dat", rsp_dat, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during the first BUS cycle.
    s_mode = 3;
    req_valid = 1'b1;
    req_we  = 1'b0;
    req_adr = 32'h30;
    @(negedge clk);
    req_valid = 1'b0;
    chk("rst_mid_cyc_before", cyc, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_cyc", {cyc, stb}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    chk("rst_mid_req_ready", req_ready, 1);
    chk("rst_mid_busy", busy, 0);

    for (int t = 0; t < 24; t++) begin
      int m;
      m = ($urandom_range(0, 7) == 0) ? 3 : $urandom_range(0, 2);
      xfer(1'($urandom), $urandom, $urandom, 4'($urandom),
           m, $urandom_range(0, 5), $urandom, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wb_req_master.md
# wb_req_master

Wishbone classic single-transfer initiator. It turns a valid/ready request stream (from the debug/JTAG side or a test sequencer) into one Wishbone read or write cycle to the uncore peripherals (GPIO, UART, …). Each transfer has a bounded wait for `ack`/`err`, and the result comes back on a valid/ready response channel. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `ADDR_W`, 32: Wishbone address width.
- `DATA_W`, 32: data width; must be a multiple of 8.
- `TIMEOUT_CYCLES`, 256: maximum cycles with `cyc` asserted before the transfer is aborted; 0 disables the timeout.

Ports:
- `wb_clk_i`  in  1  clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  1  request offered.
- `req_ready_o`  out  1  request accepted when high together with `req_valid_i`.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_adr_i`  in  ADDR_W  target address.
- `req_dat_i`  in  DATA_W  write data.
- `req_sel_i`  in  DATA_W/8  byte enables.
- `rsp_valid_o`  out  1  response available.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_dat_o`  out  DATA_W  read data; 0 for writes, errors and timeouts.
- `rsp_err_o`  out  1  slave asserted `wb_err_i`.
- `rsp_timeout_o`  out  1  transfer aborted by timeout.
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone master controls.
- `wb_adr_o`  out  ADDR_W;  `wb_dat_o`  out  DATA_W;  `wb_sel_o`  out  DATA_W/8.
- `wb_dat_i`  in  DATA_W;  `wb_ack_i`  in  1;  `wb_err_i`  in  1.
- `busy_o`  out  1  high whenever state ≠ IDLE.

## Operation
FSM with three states: IDLE, BUS, RESP.

IDLE
- `req_ready_o` = 1.
- On `req_valid_i & req_ready_o`: register `we`, `adr`, `dat` and `sel`; clear the timeout counter; go to BUS.

BUS
- `wb_cyc_o` = `wb_stb_o` = 1.
- `wb_adr_o`, `wb_dat_o`, `wb_sel_o` and `wb_we_o` are driven from the registered copies and stay stable for the whole cycle.
- The counter increments every cycle.
- `wb_err_i` sampled high: `rsp_err` = 1, `rsp_dat` = 0, go to RESP. Error has priority if ack and err are both high.
- Else `wb_ack_i` sampled high: `rsp_dat` = `wb_dat_i` for a read, 0 for a write; go to RESP.
- Else counter = TIMEOUT_CYCLES−1 (with TIMEOUT_CYCLES ≠ 0): `rsp_timeout` = 1, `rsp_dat` = 0, go to RESP.
- Request inputs are ignored; `req_ready_o` = 0.

RESP
- `rsp_valid_o` = 1; the response fields are held stable until `rsp_ready_i`.
- On `rsp_valid_o & rsp_ready_i`: go to IDLE and clear the response flags.
- `wb_cyc_o` = `wb_stb_o` = 0.

Other rules:
- The Wishbone outputs (`wb_adr_o`, `wb_dat_o`, `wb_sel_o`, `wb_we_o`) hold their last values outside BUS. Slaves qualify them with `cyc & stb`.
- Counter width is $clog2(TIMEOUT_CYCLES+1); it saturates and never wraps.
- Reset value of every output is 0 except `req_ready_o` = 1. Registered copies and `rsp_dat_o` reset to 0.
- Reset asserted mid-transfer: `cyc`/`stb` drop asynchronously, the transaction and any pending response are discarded, and the FSM is in IDLE after release.

## Timing
- All outputs are registered or decoded from state; there is no combinational path from `wb_ack_i`/`wb_err_i` to `wb_cyc_o`/`wb_stb_o`.
- Cycle A, handshake: `req_valid_i & req_ready_o`.
- Cycle A+1: `cyc`/`stb` high.
- With a slave that registers its ack (ack visible in A+2): `cyc`/`stb` low and `rsp_valid_o` high in A+3.
- With `rsp_ready_i` held at 1: `req_ready_o` high again in A+4. Minimum is 4 cycles per transfer with a registered-ack slave.
- `stb` drops the cycle after ack, so a toggling-ack slave (ack = acc & ~ack) produces exactly one ack per transfer.
- Timeout: `cyc` is high for exactly TIMEOUT_CYCLES cycles, then `rsp_valid_o` rises the next cycle.
- `rsp_valid_o` stays high until consumed. Response back-pressure stalls new requests indefinitely.

## Structure
- Package `wb_master_pkg` holds:
  - the state enum `wbm_state_e` (IDLE, BUS, RESP);
  - a response struct `wbm_rsp_t` (dat, err, timeout);
  - a request struct `wbm_req_t` (we, adr, dat, sel).
- Flat module, no sub-module. The counter and FSM are small enough to stay inline.

## Test plan
- Read from a registered-ack slave model: request adr=0x04, `we`=0; slave returns 0xA5A5_0F0F with ack in A+2. Expect `rsp_valid_o` in A+3, `rsp_dat_o`=0xA5A5_0F0F, err=timeout=0, `cyc` high for exactly 2 cycles.
- Write with adr=0x08, dat=0x1234_5678, sel=4'b0101. Expect `wb_dat_o`/`wb_sel_o`/`wb_adr_o` stable while `cyc` is high, `wb_we_o`=1, `rsp_dat_o`=0, err=0.
- Slave raises ack and err in the same cycle. Expect `rsp_err_o`=1, `rsp_dat_o`=0.
- No ack, TIMEOUT_CYCLES=8. Expect `cyc` high for 8 cycles, then `rsp_timeout_o`=1, `rsp_dat_o`=0, then a clean next transfer.
- Response back-pressure: hold `rsp_ready_i`=0 for 10 cycles with a new request pending. Expect `req_ready_o`=0 and response fields constant; the new transfer starts 1 cycle after `rsp_ready_i` rises and the FSM returns to IDLE.
- Assert reset in BUS cycle 1. Expect `cyc`/`stb`=0 in the same cycle, `rsp_valid_o`=0 and `req_ready_o`=1 after release.
